// File: rtl/output_merger_pkg.sv
// Shared definitions for the output merger: FSM encoding, depth constant,
// colour channel placement and buffer address sizing.
package output_merger_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  // Wide enough for any depth width in use; callers take the low DEPTH_W bits.
  localparam logic [63:0] DEPTH_MAX = '1;

  // Channel slot inside a packed {r,g,b} colour word (slot 0 is the LSBs).
  localparam int CH_R = 2;
  localparam int CH_G = 1;
  localparam int CH_B = 0;

  function automatic int addr_width(input int w, input int h);
    return (w * h > 1) ? $clog2(w * h) : 1;
  endfunction

endpackage

// File: rtl/output_merger_fifo.sv
// Synchronous FIFO with power-of-two depth; a push on a full FIFO is taken
// only when a pop frees a slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PTR_W-1:0]] <= din;
  end

endmodule

// File: rtl/output_merger.sv
// Output merger: buffers shaded fragments, runs a LESS depth test against an
// external depth buffer, writes passing fragments, and sequences full clears.
module output_merger
  import output_merger_pkg::*;
#(
  parameter int COORD_W    = 32,
  parameter int COLOR_W    = 24,
  parameter int DEPTH_W    = 32,
  parameter int SCREEN_W   = 1024,
  parameter int SCREEN_H   = 1024,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = addr_width(SCREEN_W, SCREEN_H)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_in,
  output logic                 ready_out,
  input  logic [COORD_W-1:0]   frag_x,
  input  logic [COORD_W-1:0]   frag_y,
  input  logic [COLOR_W-1:0]   color_r,
  input  logic [COLOR_W-1:0]   color_g,
  input  logic [COLOR_W-1:0]   color_b,
  input  logic [DEPTH_W-1:0]   depth_in,
  input  logic                 depth_test_en,
  input  logic                 clear_req,
  input  logic [3*COLOR_W-1:0] clear_color,
  output logic                 zb_rd_en,
  output logic [ADDR_W-1:0]    zb_rd_addr,
  input  logic [DEPTH_W-1:0]   zb_rd_data,
  output logic                 zb_wr_en,
  output logic [ADDR_W-1:0]    zb_wr_addr,
  output logic [DEPTH_W-1:0]   zb_wr_data,
  output logic                 fb_wr_en,
  output logic [ADDR_W-1:0]    fb_wr_addr,
  output logic [3*COLOR_W-1:0] fb_wr_data,
  input  logic                 fb_ready,
  output logic                 busy,
  output logic                 overflow,
  output logic [31:0]          pass_count,
  output logic [31:0]          reject_count
);

  localparam int RGB_W  = 3 * COLOR_W;
  localparam int FRAG_W = 1 + 2 * COORD_W + RGB_W + DEPTH_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SCREEN_W * SCREEN_H - 1);

  state_t state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt;
  logic              clearing, clr_last;

  logic [FRAG_W-1:0]  f_din, f_dout;
  logic               f_full, f_empty, f_push, f_pop;
  logic               f_tst;
  logic [COORD_W-1:0] f_x, f_y;
  logic [RGB_W-1:0]   f_rgb, in_rgb;
  logic [DEPTH_W-1:0] f_depth;
  logic               offscreen, load_p0;

  logic               vld_p0, tst_p0;
  logic [ADDR_W-1:0]  addr_p0;
  logic [DEPTH_W-1:0] depth_p0;
  logic [RGB_W-1:0]   rgb_p0;

  logic               vld_p1, tst_p1, rd_fresh_p1, pass_p1;
  logic [ADDR_W-1:0]  addr_p1;
  logic [DEPTH_W-1:0] depth_p1, hold_p1, stored_p1;
  logic [RGB_W-1:0]   rgb_p1;

  logic               vld_p2, pass_p2, wr_pend_p2;
  logic [ADDR_W-1:0]  addr_p2;
  logic [DEPTH_W-1:0] depth_p2;
  logic [RGB_W-1:0]   rgb_p2;

  logic               l_vld;
  logic [ADDR_W-1:0]  l_addr;
  logic [DEPTH_W-1:0] l_depth;

  logic stall, rd_en, commit, rej_pop, rej_w;

  always_comb begin
    in_rgb = '0;
    in_rgb[CH_R*COLOR_W +: COLOR_W] = color_r;
    in_rgb[CH_G*COLOR_W +: COLOR_W] = color_g;
    in_rgb[CH_B*COLOR_W +: COLOR_W] = color_b;
  end

  assign f_din     = {depth_test_en, frag_x, frag_y, in_rgb, depth_in};
  assign ready_out = !f_full;
  assign f_push    = valid_in && ready_out;
  assign {f_tst, f_x, f_y, f_rgb, f_depth} = f_dout;

  sync_fifo #(
    .WIDTH (FRAG_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (f_push),
    .pop   (f_pop),
    .din   (f_din),
    .dout  (f_dout),
    .full  (f_full),
    .empty (f_empty)
  );

  // A passing fragment in W waiting on the frame buffer freezes R, C and W.
  assign wr_pend_p2 = vld_p2 && pass_p2;
  assign stall      = wr_pend_p2 && !fb_ready;
  assign commit     = wr_pend_p2 && fb_ready;
  assign rd_en      = vld_p0 && !stall;

  assign offscreen = (f_x >= COORD_W'(SCREEN_W)) || (f_y >= COORD_W'(SCREEN_H));
  assign f_pop     = (state_q == ST_RUN) && !f_empty && (!vld_p0 || !stall);
  assign load_p0   = f_pop && !offscreen;
  assign rej_pop   = f_pop && offscreen;
  assign rej_w     = vld_p2 && !pass_p2;

  // Newest value for C's address: pending W write, then last commit, then memory.
  always_comb begin
    stored_p1 = rd_fresh_p1 ? zb_rd_data : hold_p1;
    if (wr_pend_p2 && (addr_p2 == addr_p1))
      stored_p1 = depth_p2;
    else if (l_vld && (l_addr == addr_p1))
      stored_p1 = l_depth;
  end

  assign pass_p1 = !tst_p1 || (depth_p1 < stored_p1);

  assign clearing = (state_q == ST_CLEAR);
  assign clr_last = (clr_cnt == LAST_ADDR);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (clear_req) state_d = ST_DRAIN;
      ST_DRAIN: if (!vld_p0 && !vld_p1 && !vld_p2) state_d = ST_CLEAR;
      ST_CLEAR: if (fb_ready && clr_last) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_RUN;
      clr_cnt      <= '0;
      vld_p0       <= 1'b0;
      vld_p1       <= 1'b0;
      vld_p2       <= 1'b0;
      pass_p2      <= 1'b0;
      rd_fresh_p1  <= 1'b0;
      l_vld        <= 1'b0;
      overflow     <= 1'b0;
      pass_count   <= '0;
      reject_count <= '0;
    end else begin
      state_q <= state_d;
      if (clearing && fb_ready) clr_cnt <= clr_last ? '0 : clr_cnt + 1'b1;
      vld_p0 <= load_p0 || (vld_p0 && stall);
      if (!stall) begin
        vld_p1  <= vld_p0;
        vld_p2  <= vld_p1;
        pass_p2 <= pass_p1;
      end
      rd_fresh_p1 <= rd_en;
      if (commit)
        l_vld <= 1'b1;
      else if (clearing && fb_ready && clr_last)
        l_vld <= 1'b0;
      if (valid_in && !ready_out) overflow <= 1'b1;
      if (commit) pass_count <= pass_count + 32'd1;
      reject_count <= reject_count + 32'(rej_pop) + 32'(rej_w);
    end
  end

  always_ff @(posedge clk) begin
    // stage R: fragment popped from the FIFO, address formed
    if (load_p0) begin
      addr_p0  <= ADDR_W'(f_y) * ADDR_W'(SCREEN_W) + ADDR_W'(f_x);
      depth_p0 <= f_depth;
      rgb_p0   <= f_rgb;
      tst_p0   <= f_tst;
    end
    // stage C: read issued, compare against forwarded depth
    if (!stall) begin
      addr_p1  <= addr_p0;
      depth_p1 <= depth_p0;
      rgb_p1   <= rgb_p0;
      tst_p1   <= tst_p0;
    end
    if (rd_fresh_p1) hold_p1 <= zb_rd_data;
    // stage W: write presented until the frame buffer accepts it
    if (!stall) begin
      addr_p2  <= addr_p1;
      depth_p2 <= depth_p1;
      rgb_p2   <= rgb_p1;
    end
    if (commit) begin
      l_addr  <= addr_p2;
      l_depth <= depth_p2;
    end
  end

  assign zb_rd_en   = rd_en;
  assign zb_rd_addr = rd_en ? addr_p0 : '0;

  always_comb begin
    zb_wr_en   = 1'b0;
    zb_wr_addr = '0;
    zb_wr_data = '0;
    fb_wr_data = '0;
    if (clearing) begin
      zb_wr_en   = fb_ready;
      zb_wr_addr = clr_cnt;
      zb_wr_data = DEPTH_MAX[DEPTH_W-1:0];
      fb_wr_data = clear_color;
    end else if (wr_pend_p2) begin
      zb_wr_en   = fb_ready;
      zb_wr_addr = addr_p2;
      zb_wr_data = depth_p2;
      fb_wr_data = rgb_p2;
    end
  end

  assign fb_wr_en   = zb_wr_en;
  assign fb_wr_addr = zb_wr_addr;
  assign busy       = (state_q != ST_RUN) || !f_empty || vld_p0 || vld_p1 || vld_p2;

endmodule

// File: tb/tb_output_merger.sv
// Bench for output_merger on a 4x4 screen: directed scenarios plus random
// traffic checked against an in-order depth/colour buffer model.
module tb_output_merger;

  localparam int SW = 4;
  localparam int SH = 4;
  localparam int NPIX = SW * SH;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in, ready_out;
  logic [31:0] frag_x, frag_y;
  logic [23:0] color_r, color_g, color_b;
  logic [31:0] depth_in;
  logic        depth_test_en, clear_req;
  logic [71:0] clear_color;
  logic        zb_rd_en;
  logic [3:0]  zb_rd_addr;
  logic [31:0] zb_rd_data;
  logic        zb_wr_en;
  logic [3:0]  zb_wr_addr;
  logic [31:0] zb_wr_data;
  logic        fb_wr_en;
  logic [3:0]  fb_wr_addr;
  logic [71:0] fb_wr_data;
  logic        fb_ready, busy, overflow;
  logic [31:0] pass_count, reject_count;

  output_merger #(
    .COORD_W(32), .COLOR_W(24), .DEPTH_W(32),
    .SCREEN_W(SW), .SCREEN_H(SH), .FIFO_DEPTH(16)
  ) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ready_out(ready_out),
    .frag_x(frag_x), .frag_y(frag_y),
    .color_r(color_r), .color_g(color_g), .color_b(color_b),
    .depth_in(depth_in), .depth_test_en(depth_test_en),
    .clear_req(clear_req), .clear_color(clear_color),
    .zb_rd_en(zb_rd_en), .zb_rd_addr(zb_rd_addr), .zb_rd_data(zb_rd_data),
    .zb_wr_en(zb_wr_en), .zb_wr_addr(zb_wr_addr), .zb_wr_data(zb_wr_data),
    .fb_wr_en(fb_wr_en), .fb_wr_addr(fb_wr_addr), .fb_wr_data(fb_wr_data),
    .fb_ready(fb_ready), .busy(busy), .overflow(overflow),
    .pass_count(pass_count), .reject_count(reject_count)
  );

  always #5 clk = ~clk;

  // External depth/frame buffers: one-cycle read latency, old data on collision.
  logic [31:0] zmem [NPIX];
  logic [71:0] fmem [NPIX];
  always_ff @(posedge clk) begin
    if (zb_rd_en) zb_rd_data <= zmem[zb_rd_addr];
    if (zb_wr_en) zmem[zb_wr_addr] <= zb_wr_data;
    if (fb_wr_en) fmem[fb_wr_addr] <= fb_wr_data;
  end

  typedef struct {
    int          addr;
    logic [31:0] d;
    logic [71:0] rgb;
  } wr_t;

  wr_t         expq[$];
  logic [31:0] ref_z  [NPIX];
  logic [71:0] ref_fb [NPIX];
  int n_cmp = 0, n_err = 0;
  int exp_pass = 0, exp_rej = 0, exp_reads = 0, n_reads = 0;
  int clr_idx = 0;
  bit clr_phase = 0;
  logic        wr_seen, rd_seen;
  logic [3:0]  rd_addr_s, wr_addr_s;
  logic [31:0] wr_data_s;
  logic [71:0] fbd_s;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Model: fragments resolve in acceptance order against the current buffer.
  task automatic accept();
    int a;
    if (frag_x >= SW || frag_y >= SH) begin
      exp_rej++;
    end else begin
      a = int'(frag_y) * SW + int'(frag_x);
      exp_reads++;
      if (!depth_test_en || depth_in < ref_z[a]) begin
        ref_z[a]  = depth_in;
        ref_fb[a] = {color_r, color_g, color_b};
        expq.push_back('{a, depth_in, {color_r, color_g, color_b}});
        exp_pass++;
      end else begin
        exp_rej++;
      end
    end
  endtask

  task automatic cyc();
    wr_t e;
    @(negedge clk);
    wr_seen = zb_wr_en; rd_seen = zb_rd_en; rd_addr_s = zb_rd_addr;
    wr_addr_s = zb_wr_addr; wr_data_s = zb_wr_data; fbd_s = fb_wr_data;
    if (zb_rd_en) n_reads++;
    if (valid_in && ready_out) accept();
    if (zb_wr_en) begin
      chk("fb_wr_en_with_zb", fb_wr_en, 1'b1);
      chk("fb_wr_addr_eq", fb_wr_addr, zb_wr_addr);
      if (clr_phase) begin
        chk("clr_addr", zb_wr_addr, clr_idx);
        chk("clr_zdata", zb_wr_data, 32'hFFFF_FFFF);
        chk("clr_fbdata", fb_wr_data, clear_color);
        clr_idx++;
      end else begin
        n_cmp++;
        assert (expq.size() != 0) else begin
          n_err++;
          $error("FAIL wr_unexpected: observed write at addr %0d, required none", zb_wr_addr);
        end
        if (expq.size() != 0) begin
          e = expq.pop_front();
          chk("wr_addr", zb_wr_addr, e.addr);
          chk("wr_zdata", zb_wr_data, e.d);
          chk("wr_fbdata", fb_wr_data, e.rgb);
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic drive(input int x, input int y, input logic [31:0] d);
    valid_in = 1'b1;
    frag_x = 32'(x); frag_y = 32'(y); depth_in = d;
    color_r = 24'($urandom()); color_g = 24'($urandom()); color_b = 24'($urandom());
  endtask

  task automatic drain(input string tag);
    int n = 0;
    valid_in = 1'b0;
    fb_ready = 1'b1;
    while ((busy || expq.size() != 0) && n < 300) begin cyc(); n++; end
    chk({tag, "_busy_low"}, busy, 1'b0);
    chk({tag, "_writes_left"}, expq.size(), 0);
  endtask

  task automatic do_reset();
    valid_in = 1'b0; clear_req = 1'b0;
    rst = 1'b0;
    #2;
    chk("rst_ready_out", ready_out, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_pass", pass_count, 0);
    chk("rst_reject", reject_count, 0);
    chk("rst_zb_wr_en", zb_wr_en, 1'b0);
    chk("rst_fb_wr_en", fb_wr_en, 1'b0);
    chk("rst_zb_rd_en", zb_rd_en, 1'b0);
    chk("rst_wr_data", {zb_wr_addr, zb_wr_data, fb_wr_data}, 0);
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    expq.delete();
    exp_pass = 0; exp_rej = 0; exp_reads = 0; n_reads = 0;
  endtask

  initial begin
    int n, r0, p0, acc;
    valid_in = 0; clear_req = 0; frag_x = 0; frag_y = 0; depth_in = 0;
    color_r = 0; color_g = 0; color_b = 0; depth_test_en = 1; fb_ready = 1;
    clear_color = 72'({$urandom(), $urandom(), $urandom()});
    rst = 1'b0;
    #1;
    do_reset();

    // Full clear; a second request mid-clear must be ignored.
    clr_phase = 1; clr_idx = 0;
    clear_req = 1'b1; cyc(); clear_req = 1'b0;
    n = 0;
    while (clr_idx < NPIX && n < 60) begin
      chk("clr_busy", busy, 1'b1);
      clear_req = (n == 5);
      cyc(); n++;
    end
    clear_req = 1'b0;
    chk("clr_count", clr_idx, NPIX);
    chk("clr_busy_after", busy, 1'b0);
    clr_phase = 0;
    for (int i = 0; i < NPIX; i++) begin ref_z[i] = '1; ref_fb[i] = clear_color; end
    repeat (20) cyc();

    // Single fragment latency: read in cycle 2, write in cycle 4.
    drive(1, 2, 32'h100); cyc(); valid_in = 0;
    chk("lat_rd_c0", rd_seen, 1'b0);
    cyc(); chk("lat_rd_c1", rd_seen, 1'b0);
    cyc(); chk("lat_rd_c2", rd_seen, 1'b1); chk("lat_rd_addr", rd_addr_s, 4'd9);
    cyc(); chk("lat_wr_c3", wr_seen, 1'b0);
    cyc(); chk("lat_wr_c4", wr_seen, 1'b1);
    chk("lat_pass", pass_count, 1);
    drain("single");

    // Back-to-back same pixel: third fragment loses to the forwarded 0x100.
    drive(3, 3, 32'h200); cyc();
    drive(3, 3, 32'h100); cyc();
    drive(3, 3, 32'h300); cyc();
    drain("b2b");
    chk("b2b_pass", pass_count, 2 + 1);
    chk("b2b_reject", reject_count, 1);

    // Off-screen fragments: rejected without any memory access.
    r0 = n_reads;
    drive(4, 0, 32'h0); cyc();
    drive(0, 4, 32'h0); cyc();
    drain("offscr");
    chk("offscr_reject", reject_count, 3);
    chk("offscr_no_reads", n_reads - r0, 0);

    // Stall with three fragments in flight.
    depth_test_en = 0; fb_ready = 0; r0 = n_reads; p0 = pass_count;
    drive(0, 0, $urandom()); cyc();
    drive(1, 0, $urandom()); cyc();
    drive(2, 0, $urandom()); cyc();
    valid_in = 0;
    repeat (3) cyc();
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("stall_no_wr", wr_seen, 1'b0);
      chk("stall_no_rd", rd_seen, 1'b0);
      chk("stall_hold_addr", wr_addr_s, expq[0].addr);
      chk("stall_hold_zdata", wr_data_s, expq[0].d);
      chk("stall_hold_fbdata", fbd_s, expq[0].rgb);
    end
    chk("stall_reads", n_reads - r0, 2);
    drain("stall");
    chk("stall_reads_total", n_reads - r0, 3);
    chk("stall_pass", pass_count - p0, 3);

    // Random traffic, depth test on then off.
    for (int seg = 0; seg < 2; seg++) begin
      depth_test_en = (seg == 0);
      for (int i = 0; i < (seg == 0 ? 300 : 80); i++) begin
        if ($urandom_range(0, 3) != 0)
          drive($urandom_range(0, 4), $urandom_range(0, 4), 32'($urandom_range(0, 255)));
        else
          valid_in = 0;
        fb_ready = ($urandom_range(0, 3) != 0);
        cyc();
      end
      drain("rand");
    end
    chk("rand_pass", pass_count, exp_pass);
    chk("rand_reject", reject_count, exp_rej);
    chk("rand_reads", n_reads, exp_reads);
    for (int i = 0; i < NPIX; i++) begin
      chk("mem_depth", zmem[i], ref_z[i]);
      chk("mem_color", fmem[i], ref_fb[i]);
    end

    // FIFO fill under a blocked frame buffer, overflow, then abort by reset.
    do_reset();
    depth_test_en = 0; fb_ready = 0; acc = 0;
    for (int i = 0; i < 40 && ready_out; i++) begin
      drive($urandom_range(0, 3), $urandom_range(0, 3), $urandom());
      acc++;
      cyc();
    end
    chk("fill_accepts", acc, 16 + 3);
    chk("fill_ready_low", ready_out, 1'b0);
    chk("fill_no_overflow", overflow, 1'b0);
    drive(0, 0, 32'h1); cyc(); valid_in = 0;
    chk("overflow_set", overflow, 1'b1);
    chk("overflow_ready_low", ready_out, 1'b0);
    fb_ready = 1;
    do_reset();
    repeat (10) cyc();
    chk("abort_no_reads", n_reads, 0);
    chk("abort_busy", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/output_merger.md
Name: output_merger

Overview:
- Downstream of the rasterization top; consumes its shaded fragment stream (x, y, r, g, b, depth).
- Performs a LESS depth test against an external depth buffer and writes passing fragments' depth and colour to the external depth and frame buffers.
- Contains an input FIFO to absorb bursts, a 3-stage read/compare/write pipeline with depth forwarding, and a full-screen clear sequencer.

Parameters:
- COORD_W, 32, fragment coordinate width, unsigned.
- COLOR_W, 24, width of each colour channel.
- DEPTH_W, 32, depth width, unsigned.
- SCREEN_W, 1024, pixels per row.
- SCREEN_H, 1024, rows.
- FIFO_DEPTH, 16, input FIFO entries; power of two.
- ADDR_W, $clog2(SCREEN_W*SCREEN_H), buffer address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (rst=0 resets immediately).
- valid_in  in  1  fragment present on the input bus.
- ready_out  out  1  FIFO not full; a fragment is accepted when valid_in && ready_out.
- frag_x, frag_y  in  COORD_W  fragment pixel position.
- color_r, color_g, color_b  in  COLOR_W  fragment colour.
- depth_in  in  DEPTH_W  fragment depth.
- depth_test_en  in  1  1 = LESS test; 0 = every on-screen fragment passes.
- clear_req  in  1  single-cycle pulse requesting a full clear.
- clear_color  in  3*COLOR_W  colour written during a clear, packed {r,g,b}.
- zb_rd_en  out  1  depth read strobe.
- zb_rd_addr  out  ADDR_W  depth read address.
- zb_rd_data  in  DEPTH_W  read data, valid the cycle after zb_rd_en.
- zb_wr_en  out  1  depth write strobe.
- zb_wr_addr  out  ADDR_W  depth write address.
- zb_wr_data  out  DEPTH_W  depth write data.
- fb_wr_en  out  1  colour write strobe.
- fb_wr_addr  out  ADDR_W  colour write address.
- fb_wr_data  out  3*COLOR_W  colour write data, packed {r,g,b}.
- fb_ready  in  1  frame buffer accepts a write this cycle; when low, stalls the pipeline.
- busy  out  1  high in DRAIN or CLEAR, or while the FIFO or pipeline holds fragments.
- overflow  out  1  sticky; set when valid_in is high while ready_out is low.
- pass_count, reject_count  out  32  wrapping fragment counters.

Behaviour:
- Reset values:
  - All outputs 0 except ready_out=1.
  - FIFO emptied, pipeline invalidated, state RUN, counters 0.
  - Asserting rst mid-clear or mid-pipeline aborts all work; no further writes are issued.
- Input handling:
  - A fragment offered while ready_out=0 is dropped and sets overflow; it is never counted.
  - A simultaneous push and pop on a full FIFO is allowed.
- Pop (RUN only, stage R empty or advancing):
  - Off-screen test: frag_x>=SCREEN_W or frag_y>=SCREEN_H. Off-screen fragments are discarded at pop with reject_count++ and no memory access.
  - On-screen fragments load R with addr = y*SCREEN_W + x.
- Stage R:
  - On the cycle R advances to C, zb_rd_en=1 and zb_rd_addr=R.addr (combinational).
  - Exactly one read is issued per fragment.
- Stage C:
  - zb_rd_data is captured into a holder the cycle after the read, including under stall.
  - Stored depth is forwarded with priority: W (pending passing write, same addr), then L (last committed write, same addr), then holder.
  - Pass when depth_in < stored, or when depth_test_en=0.
  - Memory may return old or new data on read-during-write; forwarding makes both correct.
- Stage W:
  - For a passing fragment: zb_wr_en = fb_wr_en = fb_ready; wr_addr=addr; zb_wr_data=depth; fb_wr_data={r,g,b}.
  - A write commits at the edge where fb_ready=1; commit sets L={addr, depth, valid}.
  - pass_count++ on commit; reject_count++ when a failing fragment leaves W.
- Stall: W holding a passing fragment while fb_ready=0 freezes W, C and R. Pop continues only into an empty R.
- Latency: with the pipeline empty and fb_ready=1, valid_in in cycle 0 produces fb_wr_en in cycle 4. Throughput is 1 fragment per cycle.
- FSM:
  - RUN: on clear_req, go to DRAIN; popping stops, and the FIFO keeps accepting.
  - DRAIN: when R, C and W are all empty, go to CLEAR.
  - CLEAR: counter 0..SCREEN_W*SCREEN_H-1. Each cycle with fb_ready=1 writes zb_wr_data=all-ones and fb_wr_data=clear_color to the counter address, then increments. After the last address, return to RUN and invalidate L.
  - clear_req during DRAIN or CLEAR is ignored.
- Width rules: depth compare is unsigned; the address product is truncated to ADDR_W; counters wrap at 2^32.

Decomposition:
- Package output_merger_pkg holds:
  - FSM state encoding (RUN, DRAIN, CLEAR).
  - DEPTH_MAX = all-ones.
  - Colour packing order {r,g,b}.
  - Address-width function.
- Sub-module sync_fifo (parameterised width and depth; push/pop/full/empty) instantiated once for the input stream.

Test Plan:
- SCREEN_W=SCREEN_H=4, clear_req pulse -> 16 writes, addresses 0..15, zb_wr_data=0xFFFFFFFF, fb_wr_data=clear_color; busy high throughout, low after the last write.
- After clear, one fragment (1,2) depth 0x100, fb_ready=1 -> zb_rd_addr=9 in cycle 2; zb/fb write at addr 9 with data 0x100 / {r,g,b} in cycle 4; pass_count=1.
- Back-to-back fragments at (3,3) with depths 0x200, 0x100, 0x300 -> writes 0x200 then 0x100, third rejected via forwarding; pass_count=2, reject_count=1.
- Three fragments in flight, fb_ready=0 for 5 cycles -> write outputs held stable, no extra zb_rd_en pulses, all three committed in order once fb_ready=1.
- Fragment (4,0) on a 4x4 screen -> no zb/fb strobes; reject_count increments by 1.
- fb_ready=0 with continuous valid_in -> ready_out falls after FIFO_DEPTH+3 accepts; next offered fragment sets overflow; rst=0 then clears overflow and counters.
